// File: rtl/data_mem_pkg.sv
// Shared types and constants for the dual-read data memory.
// Clear-sequencer states and read-latency selectors.
package data_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int RD_LAT_COMB = 0;
    localparam int RD_LAT_REG  = 1;

endpackage

// File: rtl/data_mem_dp_clr.sv
// Clear sequencer: walks every address once, writing INIT_VAL.
// Starts after reset or on a Clear pulse while idle.
module mem_clear_seq
    import data_mem_pkg::*;
#(
    parameter int            W        = 8,
    parameter int            A        = 8,
    parameter logic [W-1:0]  INIT_VAL = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    output logic         Busy,
    output logic         clr_we,
    output logic [A-1:0] clr_addr,
    output logic [W-1:0] clr_data
);

    localparam logic [A-1:0] LAST = '1;

    state_t       state, state_nxt;
    logic [A-1:0] ptr, ptr_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        Busy      = 1'b0;
        clr_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                Busy   = 1'b1;
                clr_we = 1'b1;
                // terminal compare instead of relying on wrap
                if (ptr == LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign clr_addr = ptr;
    assign clr_data = INIT_VAL;

endmodule

// File: rtl/data_mem_dp.sv
// 2**A x W data memory: one write port, two independent read ports,
// combinational or registered reads, built-in clear sequencer.
module data_mem_dp
    import data_mem_pkg::*;
#(
    parameter int            W        = 8,
    parameter int            A        = 8,
    parameter int            RD_LAT   = RD_LAT_REG,
    parameter logic [W-1:0]  INIT_VAL = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         MemWrite,
    input  logic [A-1:0] WrAddr,
    input  logic [W-1:0] DataIn,
    input  logic         RdEnA,
    input  logic [A-1:0] RdAddrA,
    input  logic         RdEnB,
    input  logic [A-1:0] RdAddrB,
    output logic [W-1:0] DataOutA,
    output logic [W-1:0] DataOutB,
    output logic         ValidA,
    output logic         ValidB,
    output logic         Busy
);

    logic         busy;
    logic         clr_we;
    logic [A-1:0] clr_addr;
    logic [W-1:0] clr_data;
    logic         user_we;
    logic         we;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;

    logic [W-1:0] core [2**A];

    mem_clear_seq #(
        .W        (W),
        .A        (A),
        .INIT_VAL (INIT_VAL)
    ) u_clr (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (Clear),
        .Busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    assign Busy    = busy;
    assign user_we = MemWrite & ~busy;
    assign we      = clr_we | user_we;
    assign waddr   = busy ? clr_addr : WrAddr;
    assign wdata   = busy ? clr_data : DataIn;

    always_ff @(posedge Clk) begin
        if (we) core[waddr] <= wdata;
    end

    generate
        if (RD_LAT == RD_LAT_COMB) begin : g_comb
            // array read sees pre-edge contents: read-before-write
            assign DataOutA = core[RdAddrA];
            assign DataOutB = core[RdAddrB];
            assign ValidA   = RdEnA & ~busy;
            assign ValidB   = RdEnB & ~busy;
        end else begin : g_reg
            logic acc_a, acc_b;
            logic hit_a, hit_b;

            assign acc_a = RdEnA & ~busy;
            assign acc_b = RdEnB & ~busy;
            assign hit_a = user_we & (WrAddr == RdAddrA);
            assign hit_b = user_we & (WrAddr == RdAddrB);

            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    ValidA   <= 1'b0;
                    ValidB   <= 1'b0;
                    DataOutA <= '0;
                    DataOutB <= '0;
                end else begin
                    ValidA <= acc_a;
                    ValidB <= acc_b;
                    // same-cycle write forwards DataIn
                    if (acc_a)
                        DataOutA <= hit_a ? DataIn : core[RdAddrA];
                    if (acc_b)
                        DataOutB <= hit_b ? DataIn : core[RdAddrB];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_dp.sv
// Directed bench: registered and combinational A=4 instances plus
// a registered A=8 instance, all sharing one stimulus bus.
module tb_data_mem_dp;

    logic       Clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       mw;
    logic [7:0] wa;
    logic [7:0] din;
    logic       rea;
    logic [7:0] raa;
    logic       reb;
    logic [7:0] rab;

    logic [7:0] r_da, r_db, c_da, c_db, w_da, w_db;
    logic       r_va, r_vb, c_va, c_vb, w_va, w_vb;
    logic       r_busy, c_busy, w_busy;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    data_mem_dp #(
        .W(8), .A(4), .RD_LAT(1), .INIT_VAL(8'h5A)
    ) u_r (
        .Clk      (Clk),
        .Reset    (rst),
        .Clear    (clr),
        .MemWrite (mw),
        .WrAddr   (wa[3:0]),
        .DataIn   (din),
        .RdEnA    (rea),
        .RdAddrA  (raa[3:0]),
        .RdEnB    (reb),
        .RdAddrB  (rab[3:0]),
        .DataOutA (r_da),
        .DataOutB (r_db),
        .ValidA   (r_va),
        .ValidB   (r_vb),
        .Busy     (r_busy)
    );

    data_mem_dp #(
        .W(8), .A(4), .RD_LAT(0), .INIT_VAL(8'h5A)
    ) u_c (
        .Clk      (Clk),
        .Reset    (rst),
        .Clear    (clr),
        .MemWrite (mw),
        .WrAddr   (wa[3:0]),
        .DataIn   (din),
        .RdEnA    (rea),
        .RdAddrA  (raa[3:0]),
        .RdEnB    (reb),
        .RdAddrB  (rab[3:0]),
        .DataOutA (c_da),
        .DataOutB (c_db),
        .ValidA   (c_va),
        .ValidB   (c_vb),
        .Busy     (c_busy)
    );

    data_mem_dp #(
        .W(8), .A(8), .RD_LAT(1), .INIT_VAL(8'hC3)
    ) u_w (
        .Clk      (Clk),
        .Reset    (rst),
        .Clear    (clr),
        .MemWrite (mw),
        .WrAddr   (wa),
        .DataIn   (din),
        .RdEnA    (rea),
        .RdAddrA  (raa),
        .RdEnB    (reb),
        .RdAddrB  (rab),
        .DataOutA (w_da),
        .DataOutB (w_db),
        .ValidA   (w_va),
        .ValidB   (w_vb),
        .Busy     (w_busy)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        mw  = 1'b0;
        rea = 1'b0;
        reb = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        int n_r, n_c, n_w;

        rst = 1'b0;
        idle_in();
        wa  = '0;
        din = '0;
        raa = '0;
        rab = '0;

        // 1: reset state, clear length, initial contents
        repeat (3) @(negedge Clk);
        chk("rst_busy_r", r_busy, 1);
        chk("rst_busy_c", c_busy, 1);
        chk("rst_va", r_va, 0);
        chk("rst_vb", r_vb, 0);
        chk("rst_da", r_da, 0);
        chk("rst_db", r_db, 0);
        rst = 1'b1;
        n_r = 99;
        n_c = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            if (!r_busy && n_r == 99) n_r = i;
            if (!c_busy && n_c == 99) n_c = i;
        end
        chk("busy_len_r", n_r, 16);
        chk("busy_len_c", n_c, 16);
        chk("busy_w_still", w_busy, 1);

        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                chk("init_r_va", r_va, 1);
                chk("init_r_da", r_da, 8'h5A);
                chk("init_r_db", r_db, 8'h5A);
            end
            if (i < 16) begin
                rea = 1'b1;
                raa = 8'(i);
                reb = 1'b1;
                rab = 8'(15 - i);
                #1;
                chk("init_c_da", c_da, 8'h5A);
                chk("init_c_db", c_db, 8'h5A);
                chk("init_c_va", c_va, 1);
            end else begin
                idle_in();
            end
            @(negedge Clk);
        end
        chk("noreq_va", r_va, 0);

        // 2: write then registered read
        mw  = 1'b1;
        wa  = 8'd3;
        din = 8'hA5;
        @(negedge Clk);
        mw  = 1'b0;
        rea = 1'b1;
        raa = 8'd3;
        #1;
        chk("wr3_c_da", c_da, 8'hA5);
        @(negedge Clk);
        chk("wr3_r_va", r_va, 1);
        chk("wr3_r_da", r_da, 8'hA5);
        rea = 1'b0;
        @(negedge Clk);
        chk("hold_r_va", r_va, 0);
        chk("hold_r_da", r_da, 8'hA5);

        // 3: same-cycle write/read on port B
        mw  = 1'b1;
        wa  = 8'd7;
        din = 8'h3C;
        reb = 1'b1;
        rab = 8'd7;
        #1;
        chk("rbw_c_db", c_db, 8'h5A);
        chk("rbw_c_vb", c_vb, 1);
        @(negedge Clk);
        chk("byp_r_vb", r_vb, 1);
        chk("byp_r_db", r_db, 8'h3C);
        mw = 1'b0;
        #1;
        chk("rbw_c_db2", c_db, 8'h3C);
        reb = 1'b0;

        // 4: user traffic during Busy is dropped
        clr = 1'b1;
        @(negedge Clk);
        clr = 1'b0;
        chk("clr_busy", r_busy, 1);
        repeat (15) @(negedge Clk);
        chk("clr_last_busy", r_busy, 1);
        mw  = 1'b1;
        wa  = 8'd2;
        din = 8'hFF;
        rea = 1'b1;
        raa = 8'd2;
        #1;
        chk("busy_c_va", c_va, 0);
        @(negedge Clk);
        chk("busy_r_va", r_va, 0);
        chk("busy_r_da", r_da, 8'hA5);
        chk("clr_done", r_busy, 0);
        idle_in();
        rea = 1'b1;
        raa = 8'd2;
        reb = 1'b1;
        rab = 8'd3;
        #1;
        chk("drop_c_da", c_da, 8'h5A);
        chk("clr3_c_db", c_db, 8'h5A);
        @(negedge Clk);
        chk("drop_r_da", r_da, 8'h5A);
        chk("clr3_r_db", r_db, 8'h5A);
        idle_in();

        // 5: reset mid-clear restarts, Clear while busy ignored
        mw  = 1'b1;
        wa  = 8'd15;
        din = 8'h77;
        @(negedge Clk);
        mw  = 1'b0;
        clr = 1'b1;
        @(negedge Clk);
        clr = 1'b0;
        repeat (8) @(negedge Clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", r_busy, 1);
        chk("midrst_va", r_va, 0);
        repeat (2) @(negedge Clk);
        chk("inrst_busy_c", c_busy, 1);
        rst = 1'b1;
        n_r = 99;
        n_c = 99;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clk);
            clr = (i == 5);
            if (!r_busy && n_r == 99) n_r = i;
            if (!c_busy && n_c == 99) n_c = i;
        end
        clr = 1'b0;
        chk("restart_len_r", n_r, 16);
        chk("restart_len_c", n_c, 16);
        for (int i = 0; i < 16; i++) begin
            rea = 1'b1;
            raa = 8'(i);
            #1;
            chk("restart_c_da", c_da, 8'h5A);
            @(negedge Clk);
            chk("restart_r_da", r_da, 8'h5A);
        end
        idle_in();

        // 6: A=8 instance, dual read and 256-cycle clear
        n_w = 0;
        while (w_busy && n_w < 400) begin
            @(negedge Clk);
            n_w++;
        end
        chk("w_ready", w_busy, 0);
        mw  = 1'b1;
        wa  = 8'h00;
        din = 8'h11;
        @(negedge Clk);
        wa  = 8'hFF;
        din = 8'h22;
        @(negedge Clk);
        mw  = 1'b0;
        rea = 1'b1;
        raa = 8'h00;
        reb = 1'b1;
        rab = 8'hFF;
        @(negedge Clk);
        chk("w_va", w_va, 1);
        chk("w_vb", w_vb, 1);
        chk("w_da", w_da, 8'h11);
        chk("w_db", w_db, 8'h22);
        raa = 8'hFF;
        @(negedge Clk);
        chk("w_same_da", w_da, 8'h22);
        chk("w_same_db", w_db, 8'h22);
        idle_in();
        clr = 1'b1;
        n_w = 999;
        for (int i = 1; i <= 300; i++) begin
            @(negedge Clk);
            clr = 1'b0;
            if (!w_busy && n_w == 999) n_w = i;
        end
        chk("w_clr_len", n_w, 257);
        rea = 1'b1;
        raa = 8'h00;
        reb = 1'b1;
        rab = 8'hFF;
        @(negedge Clk);
        chk("w_clr_da", w_da, 8'hC3);
        chk("w_clr_db", w_db, 8'hC3);
        idle_in();
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
